if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Instruction queue between the fetch stage and decode. Captures {pc, pcPlus4, instr} from fetch
//  each cycle it is accepted, buffers up to DEPTH entries, presents the oldest to decode
//  (first-word fall-through), and drives fetch's stall (~in_ready). Flushed on branch/jump/
//  interrupt redirect; presents a NOP bubble to decode when empty or just flushed.
// PARAMETERS
//  DEPTH   4             entries; power of 2, >= 2
//  XLEN    32            width of pc, pcPlus4, instr
//  NOP     32'h00000013  addi x0,x0,0; driven on instr_ID when out_valid=0
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  rst         in   1      synchronous, active-high reset
//  flush       in   1      redirect (taken branch/jump/interrupt); discard all entries
//  in_valid    in   1      fetch presents a valid instruction this cycle
//  in_ready    out  1      queue accepts this cycle; fetch stall = ~in_ready
//  pc_IF       in   XLEN   pc of presented instruction
//  pcPlus4_IF  in   XLEN   pc+4 of presented instruction
//  instr_IF    in   XLEN   presented instruction word
//  out_ready   in   1      decode consumes head this cycle (= ~stall_ID)
//  out_valid   out  1      head entry valid
//  pc_ID       out  XLEN   head pc (0 when empty)
//  pcPlus4_ID  out  XLEN   head pc+4 (0 when empty)
//  instr_ID    out  XLEN   head instruction (NOP when empty)
//  count       out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (sync, highest priority): wr_ptr=rd_ptr=0, count=0 -> out_valid=0, instr_ID=NOP,
//    pc_ID=pcPlus4_ID=0, in_ready=1. Storage contents not reset.
//  - push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
//  - in_ready = (count != DEPTH); depends on registered count only -- no comb path
//    from out_ready to in_ready. Full + pop same cycle: push refused, one slot frees next cycle.
//  - push: entry written at wr_ptr, wr_ptr+1 mod DEPTH. pop: rd_ptr+1 mod DEPTH.
//  - count_next = count + push - pop; push & pop together -> count unchanged.
//  - Latency: entry pushed in cycle N appears on *_ID in cycle N+1 (if it is the head).
//  - Outputs combinational from head entry and count: out_valid=(count!=0);
//    when count==0 outputs forced to NOP/0/0 regardless of storage.
//  - Pop with count==0 ignored (out_valid=0 gates it); pointers never move on empty.
//  - flush (priority below rst, above push/pop): next cycle wr_ptr=rd_ptr=0, count=0;
//    same-cycle in_valid entry is discarded (wrong path), same-cycle pop not counted.
//    in_ready stays as computed from count during the flush cycle.
//  - Pointers are $clog2(DEPTH) bits; wrap is natural overflow. No over/underflow possible.
//  - No X-propagation masking: in_valid/out_ready/flush are expected 0/1 after reset.
// STRUCTURE
//  - Package if_id_pkg: localparam NOP_INSTR = 32'h00000013; typedef struct packed
//    {logic [31:0] pc; logic [31:0] pcPlus4; logic [31:0] instr;} if_id_entry_t.
//  - One sub-module: sync_fifo #(WIDTH, DEPTH) (storage, ptrs, count, sync clear).
//    if_id_queue adds flush gating, NOP/zero masking of empty head, and port packing.
// TESTING
//  1 Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, instr_ID=32'h13, count=0,
//    in_ready=1; first cycle after release pushes, out_valid=1 next cycle.
//  2 Fill/back-pressure: out_ready=0, push pc=0,4,8,C (instr A0..A3) -> count=4, in_ready=0;
//    5th presented (pc=10) not accepted; then out_ready=1 -> drains 0,4,8,C,10 in order.
//  3 Streaming: in_valid=out_ready=1 for 20 cycles, pc step 4 -> count stays 1, pc_ID lags
//    pc_IF by exactly 1 cycle, no gaps or duplicates.
//  4 Flush: count=3, assert flush with in_valid=1 (pc=40) and out_ready=1 -> next cycle
//    count=0, instr_ID=NOP; pc=40 never appears; pc=100 pushed after appears next.
//  5 Wrap: push/pop 11 entries through DEPTH=4 with random out_ready -> order preserved,
//    count matches reference model every cycle.
//  6 Full + pop same cycle: count=4, in_valid=1, out_ready=1 -> in_ready=0 that cycle,
//    count=3 next, in_ready=1, pending entry accepted then.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package if_id_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] instr;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_sync_fifo.sv
// Circular-buffer FIFO with occupancy count and a synchronous clear.
// Pushes to a full FIFO and pops from an empty FIFO are ignored.
module sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_en_s;
  logic             pop_en_s;

  assign push_en_s = push & (count_r != CW'(DEPTH)) & ~clr;
  assign pop_en_s  = pop & (count_r != {CW{1'b0}}) & ~clr;

  // Storage is deliberately left unreset; the count masks stale contents.
  always_ff @(posedge clk) begin
    if (push_en_s && !rst) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: first-word fall-through FIFO with redirect
// flush, and a NOP bubble presented to decode whenever the queue is empty.
import if_id_pkg::*;

module if_id_queue #(
  parameter int          DEPTH = 4,
  parameter int          XLEN  = 32,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        pc_IF,
  input  logic [XLEN-1:0]        pcPlus4_IF,
  input  logic [XLEN-1:0]        instr_IF,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [XLEN-1:0]        pc_ID,
  output logic [XLEN-1:0]        pcPlus4_ID,
  output logic [XLEN-1:0]        instr_ID,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = 3 * XLEN;

  logic               push_s;
  logic               pop_s;
  logic [ENTRY_W-1:0] wr_data_s;
  logic [ENTRY_W-1:0] rd_data_s;
  logic [CW-1:0]      count_s;

  // in_ready looks only at the registered count, so no out_ready->in_ready path.
  assign in_ready  = (count_s != CW'(DEPTH));
  assign out_valid = (count_s != {CW{1'b0}});
  assign push_s    = in_valid & in_ready & ~flush;
  assign pop_s     = out_valid & out_ready & ~flush;
  assign wr_data_s = {pc_IF, pcPlus4_IF, instr_IF};
  assign count     = count_s;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (wr_data_s),
    .rd_data (rd_data_s),
    .count   (count_s)
  );

  // Empty head presents a bubble rather than whatever stale word sits in storage.
  always_comb begin
    pc_ID      = {XLEN{1'b0}};
    pcPlus4_ID = {XLEN{1'b0}};
    instr_ID   = XLEN'(NOP);
    if (out_valid) begin
      pc_ID      = rd_data_s[3*XLEN-1:2*XLEN];
      pcPlus4_ID = rd_data_s[2*XLEN-1:XLEN];
      instr_ID   = rd_data_s[XLEN-1:0];
    end else begin
      pc_ID      = {XLEN{1'b0}};
      pcPlus4_ID = {XLEN{1'b0}};
      instr_ID   = XLEN'(NOP);
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, back-pressure, streaming, flush, wrap, full+pop.
import if_id_pkg::*;

module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_IF;
  logic [31:0] pcPlus4_IF;
  logic [31:0] instr_IF;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] pc_ID;
  logic [31:0] pcPlus4_ID;
  logic [31:0] instr_ID;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  if_id_queue #(.DEPTH(4), .XLEN(32), .NOP(32'h00000013)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pc_IF      (pc_IF),
    .pcPlus4_IF (pcPlus4_IF),
    .instr_IF   (instr_IF),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .pc_ID      (pc_ID),
    .pcPlus4_ID (pcPlus4_ID),
    .instr_ID   (instr_ID),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] ins);
    in_valid   = 1'b1;
    pc_IF      = pc;
    pcPlus4_IF = pc + 32'd4;
    instr_IF   = ins;
  endtask

  if_id_entry_t model_q[$];
  if_id_entry_t exp_e;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    present(32'h500, 32'hAAAA_0000);

    // 1: reset with in_valid high
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr_ID, 32'h13);
    chk("rst_pc",    pc_ID, 32'd0);
    chk("rst_p4",    pcPlus4_ID, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_pc",    pc_ID, 32'h500);
    chk("post_rst_p4",    pcPlus4_ID, 32'h504);
    chk("post_rst_instr", instr_ID, 32'hAAAA_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_drain", {29'd0, count}, 32'd0);

    // 2: fill with back-pressure, then drain in order
    for (int i = 0; i < 4; i++) begin
      present(32'(4 * i), 32'hA0 + 32'(i));
      tick();
    end
    present(32'h10, 32'hA4);
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("fill_hold_count", {29'd0, count}, 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_pc",    pc_ID, 32'(4 * k));
      chk("drain_instr", instr_ID, 32'hA0 + 32'(k));
      if (k == 0) chk("drain_ready0", {31'd0, in_ready}, 32'd0);
      if (k == 1) chk("drain_ready1", {31'd0, in_ready}, 32'd1);
      tick();
      if (k == 1) in_valid = 1'b0;
    end
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_nop",   instr_ID, 32'h13);
    chk("drain_pc0",   pc_ID, 32'd0);

    // 3: streaming, one-cycle lag, occupancy steady at 1
    for (int i = 0; i < 20; i++) begin
      present(32'h200 + 32'(4 * i), 32'h5000 + 32'(i));
      if (i > 0) begin
        chk("stream_pc",    pc_ID, 32'h200 + 32'(4 * (i - 1)));
        chk("stream_count", {29'd0, count}, 32'd1);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_last", pc_ID, 32'h200 + 32'(4 * 19));
    tick();
    chk("stream_end", {29'd0, count}, 32'd0);

    // 4: flush discards contents and the same-cycle wrong-path entry
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(32'h30 + 32'(4 * i), 32'h30);
      tick();
    end
    chk("pre_flush_count", {29'd0, count}, 32'd3);
    flush = 1'b1; out_ready = 1'b1;
    present(32'h40, 32'h40);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_nop",   instr_ID, 32'h13);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    present(32'h100, 32'h100);
    tick();
    in_valid = 1'b0;
    chk("post_flush_pc",    pc_ID, 32'h100);
    chk("post_flush_count", {29'd0, count}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("post_flush_empty", {29'd0, count}, 32'd0);

    // 5: wrap with random back-pressure against a reference queue
    begin
      int pushed = 0;
      int popped = 0;
      int cyc = 0;
      logic exp_rdy, exp_vld, do_push, do_pop;
      while (popped < 11 && cyc < 300) begin
        if (pushed < 11) present(32'h800 + 32'(4 * pushed), 32'h9000 + 32'(pushed));
        else in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        exp_rdy = (model_q.size() != 4);
        exp_vld = (model_q.size() != 0);
        chk("wrap_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("wrap_valid", {31'd0, out_valid}, {31'd0, exp_vld});
        if (exp_vld) begin
          chk("wrap_pc",    pc_ID, model_q[0].pc);
          chk("wrap_p4",    pcPlus4_ID, model_q[0].pcPlus4);
          chk("wrap_instr", instr_ID, model_q[0].instr);
        end
        do_push = in_valid & exp_rdy;
        do_pop  = exp_vld & out_ready;
        tick();
        if (do_pop) begin
          void'(model_q.pop_front());
          popped++;
        end
        if (do_push) begin
          exp_e.pc = pc_IF; exp_e.pcPlus4 = pcPlus4_IF; exp_e.instr = instr_IF;
          model_q.push_back(exp_e);
          pushed++;
        end
        chk("wrap_count", {29'd0, count}, 32'(model_q.size()));
        cyc++;
      end
      chk("wrap_done", 32'(popped), 32'd11);
    end
    in_valid = 1'b0;

    // 6: full and pop in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(32'h600 + 32'(4 * i), 32'h600 + 32'(i));
      tick();
    end
    present(32'h610, 32'h604);
    out_ready = 1'b1;
    chk("fullpop_ready", {31'd0, in_ready}, 32'd0);
    chk("fullpop_count", {29'd0, count}, 32'd4);
    tick();
    out_ready = 1'b0;
    chk("fullpop_count_next", {29'd0, count}, 32'd3);
    chk("fullpop_ready_next", {31'd0, in_ready}, 32'd1);
    chk("fullpop_head",       pc_ID, 32'h604);
    tick();
    in_valid = 1'b0;
    chk("fullpop_accept", {29'd0, count}, 32'd4);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("fullpop_order", pc_ID, 32'h600 + 32'(4 * k));
      tick();
    end
    chk("fullpop_empty", {29'd0, count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
